// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and shared-memory signals around the arbiter.
// slave is the arbiter's view; master is the view of the clients plus the memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory: data wins ties, fetch is forced in after
// STARVE_MAX consecutive data grants; each access is a grant cycle plus BUSY until mem_ack.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          grant_i, grant_d;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;

  assign starved = (starve_cnt == CW'(STARVE_MAX));
  assign grant_i = (state == IDLE) && bus.if_req && (!bus.d_req || starved);
  assign grant_d = (state == IDLE) && bus.d_req && !grant_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = BUSY_I;
        end else if (grant_d) begin
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Done pulses come straight from mem_ack so the client sees completion in the ack cycle.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wstrb = 4'b0000;
    bus.if_done   = 1'b0;
    bus.d_done    = 1'b0;
    case (state)
      BUSY_I: begin
        bus.mem_req = 1'b1;
        bus.if_done = bus.mem_ack;
      end
      BUSY_D: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = req_we;
        bus.mem_wstrb = req_wstrb;
        bus.d_done    = bus.mem_ack;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = req_addr;
  assign bus.mem_wdata = req_wdata;
  assign bus.if_rdata  = bus.if_done ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata   = (bus.d_done && !req_we) ? bus.mem_rdata : 32'h0;
  assign bus.if_stall  = bus.if_req && !bus.if_done;
  assign bus.d_stall   = bus.d_req && !bus.d_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we     <= 1'b0;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      req_wstrb  <= 4'b0000;
      starve_cnt <= '0;
    end else if (grant_i) begin
      req_we     <= 1'b0;
      req_addr   <= bus.if_addr & 32'hFFFF_FFFC;
      req_wdata  <= 32'h0;
      req_wstrb  <= 4'b0000;
      starve_cnt <= '0;
    end else if (grant_d) begin
      req_we     <= bus.d_we;
      req_addr   <= bus.d_addr & 32'hFFFF_FFFC;
      req_wdata  <= bus.d_wdata;
      req_wstrb  <= bus.d_we ? bus.d_wstrb : 4'b0000;
      if (bus.if_req && !starved) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
endmodule
